// File: rtl/opcode_timing_decoder_pkg.sv
// Shared types and constants for the opcode/timing decoder.
// Holds the RUN/HALTED state type, the default bus widths and a one-hot
// helper used when checking decoded buses.
package opcode_timing_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam int DEF_OP_W  = 3;
    localparam int DEF_SEQ_W = 4;
    localparam int INSN_W    = 2**DEF_OP_W;
    localparam int T_W       = 2**DEF_SEQ_W;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/opcode_timing_decoder_onehot_decoder.sv
// Binary-to-one-hot decoder: bit k of onehot is set iff idx == k.
// idx is treated as unsigned.
module onehot_decoder #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]     idx,
    output logic [2**IN_W-1:0]  onehot
);

    // Decode idx onto a single set bit.
    always_comb begin
        // NOTE: default every bit first so no path leaves onehot unassigned (no latch).
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/opcode_timing_decoder.sv
// Opcode register + sequence counter with one-hot instruction/timing decode
// and a RUN/HALTED state machine.
// Optional: define OPCODE_TIMING_DECODER_OUTREG_EN to register every output
// through one extra stage (all outputs stay aligned, reset values unchanged).
module opcode_timing_decoder
    import opcode_timing_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int SEQ_W = DEF_SEQ_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ir_load,
    input  logic [OP_W-1:0]      opcode_in,
    input  logic                 sc_clr,
    input  logic                 halt,
    input  logic                 resume,
    output logic [2**OP_W-1:0]   instruction,
    output logic [2**SEQ_W-1:0]  timing,
    output logic [SEQ_W-1:0]     sc_value,
    output logic                 sc_wrap,
    output logic                 halted
);

    state_t             state;
    logic [OP_W-1:0]    opcode_reg;
    logic [SEQ_W-1:0]   sc;
    logic               wrap_r;

    logic [2**OP_W-1:0]  insn_d;
    logic [2**SEQ_W-1:0] sc_onehot;
    logic [2**SEQ_W-1:0] timing_d;
    logic                halted_d;

    // Opcode register, sequence counter, wrap flag and RUN/HALTED control.
    // NOTE: asynchronous reset clears every state bit without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            opcode_reg <= '0;
            sc         <= '0;
            wrap_r     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if (ir_load)
                opcode_reg <= opcode_in;
            wrap_r <= 1'b0;
            case (state)
                RUN: begin
                    if (halt) begin
                        state <= HALTED;
                        if (sc_clr)
                            sc <= '0;
                    end else if (sc_clr) begin
                        sc <= '0;
                    end else begin
                        sc <= sc + 1'b1;
                        if (sc == '1)
                            wrap_r <= 1'b1;
                    end
                end
                HALTED: begin
                    // sc_clr and halt are ignored; resume restarts at T0.
                    if (resume) begin
                        state <= RUN;
                        sc    <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    onehot_decoder #(.IN_W(OP_W)) u_insn_dec (
        .idx    (opcode_reg),
        .onehot (insn_d)
    );

    onehot_decoder #(.IN_W(SEQ_W)) u_time_dec (
        .idx    (sc),
        .onehot (sc_onehot)
    );

    // Timing lines are blanked while halted.
    always_comb begin
        halted_d = (state == HALTED);
        timing_d = halted_d ? '0 : sc_onehot;
    end

`ifdef OPCODE_TIMING_DECODER_OUTREG_EN
    // Output stage: one extra cycle of latency on every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= {{(2**OP_W-1){1'b0}}, 1'b1};
            timing      <= {{(2**SEQ_W-1){1'b0}}, 1'b1};
            sc_value    <= '0;
            sc_wrap     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instruction <= insn_d;
            timing      <= timing_d;
            sc_value    <= sc;
            sc_wrap     <= wrap_r;
            halted      <= halted_d;
        end
    end
`else
    assign instruction = insn_d;
    assign timing      = timing_d;
    assign sc_value    = sc;
    assign sc_wrap     = wrap_r;
    assign halted      = halted_d;
`endif

endmodule

// File: tb/tb_opcode_timing_decoder.sv
// Self-checking bench for opcode_timing_decoder: a behavioural model pushes
// expected outputs into a scoreboard queue each edge; entries are popped and
// compared when the DUT output is sampled on the falling edge.
module tb_opcode_timing_decoder;
    import opcode_timing_pkg::*;

`ifdef OPCODE_TIMING_DECODER_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ir_load = 1'b0;
    logic [DEF_OP_W-1:0] opcode_in = '0;
    logic                sc_clr = 1'b0;
    logic                halt = 1'b0;
    logic                resume = 1'b0;
    logic [INSN_W-1:0]   instruction;
    logic [T_W-1:0]      timing;
    logic [DEF_SEQ_W-1:0] sc_value;
    logic                sc_wrap;
    logic                halted;

    opcode_timing_decoder #(.OP_W(DEF_OP_W), .SEQ_W(DEF_SEQ_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir_load     (ir_load),
        .opcode_in   (opcode_in),
        .sc_clr      (sc_clr),
        .halt        (halt),
        .resume      (resume),
        .instruction (instruction),
        .timing      (timing),
        .sc_value    (sc_value),
        .sc_wrap     (sc_wrap),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] tim;
        logic [31:0] sc;
        logic [31:0] wrap;
        logic [31:0] hlt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_op;
    int m_sc;
    bit m_halted;
    bit m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t exp_now();
        exp_t e;
        e.insn = 32'd1 << m_op;
        e.tim  = m_halted ? 32'd0 : (32'd1 << m_sc);
        e.sc   = 32'(m_sc);
        e.wrap = {31'd0, m_wrap};
        e.hlt  = {31'd0, m_halted};
        return e;
    endfunction

    task automatic model_reset();
        m_op = 0; m_sc = 0; m_halted = 0; m_wrap = 0;
        sb.delete();
        for (int i = 0; i < LAT; i++) sb.push_back(exp_now());
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        if (ir_load) m_op = int'(opcode_in);
        m_wrap = 0;
        if (!m_halted) begin
            if (halt) begin
                m_halted = 1;
                if (sc_clr) m_sc = 0;
            end else if (sc_clr) begin
                m_sc = 0;
            end else begin
                if (m_sc == T_W - 1) m_wrap = 1;
                m_sc = (m_sc + 1) % T_W;
            end
        end else if (resume) begin
            m_halted = 0;
            m_sc = 0;
        end
        sb.push_back(exp_now());
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("instruction", 32'(instruction), e.insn);
            check("timing", 32'(timing), e.tim);
            check("sc_value", 32'(sc_value), e.sc);
            check("sc_wrap", {31'd0, sc_wrap}, e.wrap);
            check("halted", {31'd0, halted}, e.hlt);
            check("insn_onehot", {31'd0, is_onehot(32'(instruction))}, 32'd1);
        end
    endtask

    task automatic run_until_sc(input int target);
        for (int i = 0; i < 40 && m_sc != target; i++) cycle();
        check("reach_sc", 32'(m_sc), 32'(target));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_insn"}, 32'(instruction), 32'h1);
        check({tag, "_timing"}, 32'(timing), 32'h1);
        check({tag, "_sc"}, 32'(sc_value), 32'h0);
        check({tag, "_wrap"}, {31'd0, sc_wrap}, 32'h0);
        check({tag, "_halted"}, {31'd0, halted}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        #1 rst_n = 1'b1;
        model_reset();

        // 1: free run through a full wrap.
        repeat (17) cycle();

        // 2: opcodes 7..0 then random ones.
        ir_load = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            opcode_in = DEF_OP_W'(k);
            cycle();
        end
        for (int k = 0; k < 8; k++) begin
            opcode_in = DEF_OP_W'($urandom_range(0, INSN_W - 1));
            cycle();
        end
        ir_load = 1'b0;

        // 3: clear at SC=3 and at SC=15 (no wrap pulse).
        run_until_sc(3);
        sc_clr = 1'b1; cycle(); sc_clr = 1'b0;
        cycle();
        run_until_sc(T_W - 1);
        sc_clr = 1'b1; cycle(); sc_clr = 1'b0;
        repeat (2) cycle();

        // 4: halt at SC=5, hold with ignored clears, resume.
        run_until_sc(5);
        halt = 1'b1; cycle(); halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sc_clr = k[0];
            cycle();
        end
        sc_clr = 1'b0;
        resume = 1'b1; cycle(); resume = 1'b0;
        repeat (2) cycle();
        // resume while running does nothing
        resume = 1'b1; cycle(); resume = 1'b0;
        // halt + resume in RUN -> HALTED
        halt = 1'b1; resume = 1'b1; cycle();
        halt = 1'b0; resume = 1'b0;
        repeat (3) cycle();
        // halt + resume in HALTED -> RUN
        halt = 1'b1; resume = 1'b1; cycle();
        halt = 1'b0; resume = 1'b0;
        repeat (3) cycle();

        // 5: asynchronous reset between edges at SC=9 with opcode 5.
        ir_load = 1'b1; opcode_in = 3'd5; cycle(); ir_load = 1'b0;
        run_until_sc(9);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        #1 rst_n = 1'b1;
        model_reset();
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
